iir_decim: RTL and testbench
============================

# iir_decim

Decimating output buffer placed directly downstream of the low-pass IIR stage. It consumes the filter's 16-bit signed sample stream (`I_DV`/`DI` strobe interface). It boxcar-averages each group of `DECIM` consecutive samples into one output sample and queues results in a small FIFO. Results leave through a valid/ready handshake toward the consumer, for example a serializer or DMA.

## Interface
- `DECIM`, default 4: decimation ratio; power of two, 2..256.
- `DEPTH`, default 8: FIFO entries; power of two, ≥2.
- `CLK` input, 1: single clock, rising edge.
- `RESET` input, 1: asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- `I_DV` input, 1: input sample strobe, one sample per high cycle.
- `DI` input, 16: signed input sample (filter output).
- `O_DV` output, 1: FIFO head valid.
- `DO` output, 16: signed averaged sample at FIFO head.
- `I_RDY` input, 1: consumer ready. Pop occurs when `O_DV && I_RDY`.
- `OVF` output, 1: sticky overflow flag.
- `FILL` output, clog2(DEPTH)+1: current FIFO occupancy.

## Operation
- Reset values: `O_DV`=0, `DO`=0, `OVF`=0, `FILL`=0. Internal phase counter=0, accumulator=0, FIFO pointers=0.
- **Phase counter** runs 0..DECIM-1 and advances only on `I_DV`. When `I_DV` is low, all state holds.
- **Accumulator** is signed, 16+log2(DECIM) bits wide; it cannot overflow.
  - On `I_DV` with phase < DECIM-1: acc ← acc + DI.
  - On `I_DV` with phase = DECIM-1: result = (acc + DI) >>> log2(DECIM). This is an arithmetic shift with floor rounding, truncated to 16 bits, which is lossless. Then acc ← 0 and phase ← 0, and a push of the result is requested.
- **FIFO** is show-ahead. `DO` always shows the head entry while `O_DV`=1. When empty, `DO` holds its last value (0 after reset).
- **Push/pop rules:**
  - Push when not full: write.
  - Push when full with a same-cycle pop: both occur; `FILL` is unchanged; no overflow.
  - Push when full without a pop: the result is dropped, `OVF` is set to 1, and FIFO contents are unchanged.
  - Pop when empty: impossible, since `O_DV`=0.
- `OVF` clears only on `RESET`.
- **Reset mid-operation** discards any partial group and all queued results. The first `I_DV` after reset deassertion is phase 0.
- There is no state machine beyond the phase counter and the FIFO pointers. Pointer wrap uses an extra MSB to distinguish full from empty.

## Timing
- Latency: the result of a group whose last sample strobes in cycle t is registered at the edge ending cycle t. `O_DV`=1 and `DO` are valid in cycle t+1.
- There is no combinational path from `DI`/`I_DV` to outputs.
- `I_RDY` affects state only at the next edge. `O_DV` may fall in the cycle after the last pop.
- `FILL` is registered and updates on the same edge as the push/pop.
- `OVF` rises in cycle t+1 after a dropped push in cycle t.
- Throughput: one input sample per cycle sustained; one output per DECIM inputs.

## Structure
- Shared package `iir_pkg`:
  - `SAMPLE_W`=16.
  - Signed sample typedef.
  - `clog2` helper, if not already present.
- Sub-module `iir_sync_fifo`, parameterized by width and depth:
  - Show-ahead read.
  - Full/empty from wrap-bit pointers.
  - Exposes `fill`.
- The top level holds the phase counter, accumulator, overflow logic and FIFO instance.

## Test plan
All scenarios use DECIM=4, DEPTH=4.
- DI=100,200,300,400 on consecutive `I_DV` cycles, `I_RDY`=1 → `DO`=250 with `O_DV`=1 for exactly one cycle, starting one cycle after the 4th strobe.
- DI=-1,-1,-1,-2 → `DO`=-2 (sum -5, floor). DI=1,1,1,2 → `DO`=1. DI=32767×4 → 32767. DI=-32768×4 → -32768.
- `I_RDY`=0 with 5 groups of constant values 1..5 → `FILL`=4 and `OVF`=1 one cycle after the 5th group. Raising `I_RDY` then drains 1,2,3,4 in order, and `FILL` ends at 0.
- FIFO full and `I_RDY`=1 on the same cycle a group completes → `FILL` stays 4, `OVF` stays 0, and the new value appears at the tail.
- `I_DV` gaps: samples 8,8 with 3 idle cycles between each and then 8,8 → `DO`=8, and the phase is unaffected by idle cycles.
- `RESET` pulse after 2 samples of a group with 2 results queued → all outputs 0 asynchronously. Then 4,4,4,4 → `DO`=4, with no stale data emitted.

Source files
------------

// File: rtl/iir_pkg.sv
// Shared types and helpers for the IIR filter chain.
package iir_pkg;
  localparam int unsigned SAMPLE_W = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p << 1) r++;
    return r;
  endfunction
endpackage

// File: rtl/iir_sync_fifo.sv
// Show-ahead synchronous FIFO with wrap-bit pointers and a registered fill count.
module iir_sync_fifo
  import iir_pkg::*;
#(
  parameter int unsigned WIDTH = SAMPLE_W,
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   valid,
  output logic                   full,
  output logic [clog2(DEPTH):0]  fill
);
  localparam int unsigned AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic [WIDTH-1:0] last;
  logic             do_push, do_pop;

  assign valid   = (wr_ptr != rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && valid;
  // A full FIFO still accepts a write when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);
  assign rdata   = valid ? mem[rd_ptr[AW-1:0]] : last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
      last   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        last   <= mem[rd_ptr[AW-1:0]];
      end
      case ({do_push, do_pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/iir_decim.sv
// Boxcar decimator: averages DECIM input samples into one output queued in a FIFO.
module iir_decim
  import iir_pkg::*;
#(
  parameter int unsigned DECIM = 4,
  parameter int unsigned DEPTH = 8
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  I_DV,
  input  logic [SAMPLE_W-1:0]   DI,
  output logic                  O_DV,
  output logic [SAMPLE_W-1:0]   DO,
  input  logic                  I_RDY,
  output logic                  OVF,
  output logic [clog2(DEPTH):0] FILL
);
  localparam int unsigned LD    = clog2(DECIM);
  localparam int unsigned ACC_W = SAMPLE_W + LD;

  logic        [LD-1:0]       phase;
  logic signed [ACC_W-1:0]    acc, sum;
  logic        [SAMPLE_W-1:0] result;
  logic                       group_end, pop, full;

  assign sum       = acc + {{LD{DI[SAMPLE_W-1]}}, DI};
  // Dropping the low LD bits of a signed sum is an arithmetic shift with floor rounding.
  assign result    = sum[ACC_W-1:LD];
  assign group_end = I_DV && (phase == LD'(DECIM - 1));
  assign pop       = O_DV && I_RDY;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      phase <= '0;
      acc   <= '0;
      OVF   <= 1'b0;
    end else begin
      if (I_DV) begin
        if (group_end) begin
          phase <= '0;
          acc   <= '0;
        end else begin
          phase <= phase + 1'b1;
          acc   <= sum;
        end
      end
      if (group_end && full && !pop) OVF <= 1'b1;
    end
  end

  iir_sync_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RESET),
    .push  (group_end),
    .pop   (I_RDY),
    .wdata (result),
    .rdata (DO),
    .valid (O_DV),
    .full  (full),
    .fill  (FILL)
  );
endmodule

// File: tb/tb_iir_decim.sv
// Testbench for iir_decim (DECIM=4, DEPTH=4) with a queue-based reference model.
module tb_iir_decim;
  logic        CLK = 1'b0;
  logic        RESET;
  logic        I_DV;
  logic [15:0] DI;
  logic        O_DV;
  logic [15:0] DO;
  logic        I_RDY;
  logic        OVF;
  logic [2:0]  FILL;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  int q[$];
  int m_phase = 0;
  int m_sum = 0;
  int m_last = 0;
  bit m_ovf = 1'b0;

  typedef struct {
    int di[4];
    int exp;
  } grp_t;
  grp_t tbl[5];

  iir_decim #(.DECIM(4), .DEPTH(4)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .I_DV  (I_DV),
    .DI    (DI),
    .O_DV  (O_DV),
    .DO    (DO),
    .I_RDY (I_RDY),
    .OVF   (OVF),
    .FILL  (FILL)
  );

  always #5 CLK = ~CLK;

  function automatic int floor_div4(input int s);
    int r;
    r = ((s % 4) + 4) % 4;
    return (s - r) / 4;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_phase = 0;
    m_sum = 0;
    m_last = 0;
    m_ovf = 1'b0;
  endtask

  task automatic model_edge(input bit dv, input int di, input bit rdy);
    bit pop, push;
    int res;
    pop = (q.size() > 0) && rdy;
    push = 1'b0;
    res = 0;
    if (dv) begin
      m_sum += di;
      if (m_phase == 3) begin
        push = 1'b1;
        res = floor_div4(m_sum);
        m_sum = 0;
        m_phase = 0;
      end else begin
        m_phase++;
      end
    end
    if (pop) m_last = q.pop_front();
    if (push) begin
      if (q.size() < 4) q.push_back(res);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic check_model();
    chk("o_dv", int'(O_DV), (q.size() > 0) ? 1 : 0);
    chk("do", int'($signed(DO)), (q.size() > 0) ? q[0] : m_last);
    chk("fill", int'(FILL), q.size());
    chk("ovf", int'(OVF), int'(m_ovf));
  endtask

  task automatic step(input bit dv, input int di, input bit rdy);
    I_DV = dv;
    DI = 16'(di);
    I_RDY = rdy;
    model_edge(dv, di, rdy);
    @(posedge CLK);
    #1;
    check_model();
  endtask

  task automatic group(input int v, input bit rdy);
    for (int i = 0; i < 4; i++) step(1'b1, v, rdy);
  endtask

  // Asserts reset mid-cycle and checks outputs clear before any clock edge.
  task automatic pulse_reset();
    I_DV = 1'b0;
    I_RDY = 1'b0;
    #2;
    RESET = 1'b1;
    model_reset();
    #1;
    chk("rst_o_dv", int'(O_DV), 0);
    chk("rst_do", int'($signed(DO)), 0);
    chk("rst_fill", int'(FILL), 0);
    chk("rst_ovf", int'(OVF), 0);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
  endtask

  initial begin
    tbl[0] = '{di: '{100, 200, 300, 400}, exp: 250};
    tbl[1] = '{di: '{-1, -1, -1, -2}, exp: -2};
    tbl[2] = '{di: '{1, 1, 1, 2}, exp: 1};
    tbl[3] = '{di: '{32767, 32767, 32767, 32767}, exp: 32767};
    tbl[4] = '{di: '{-32768, -32768, -32768, -32768}, exp: -32768};

    RESET = 1'b1;
    I_DV = 1'b0;
    DI = '0;
    I_RDY = 1'b0;
    #1;
    chk("reset_o_dv", int'(O_DV), 0);
    chk("reset_do", int'($signed(DO)), 0);
    chk("reset_fill", int'(FILL), 0);
    chk("reset_ovf", int'(OVF), 0);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RESET = 1'b0;

    // Averaging table: one result visible for exactly one cycle
    for (int g = 0; g < 5; g++) begin
      for (int i = 0; i < 4; i++) step(1'b1, tbl[g].di[i], 1'b1);
      chk("tbl_o_dv", int'(O_DV), 1);
      chk("tbl_do", int'($signed(DO)), tbl[g].exp);
      step(1'b0, 0, 1'b1);
      chk("tbl_one_cycle", int'(O_DV), 0);
      step(1'b0, 0, 1'b1);
    end

    // Overflow: five groups with consumer stalled
    for (int v = 1; v <= 5; v++) group(v, 1'b0);
    chk("ovf_fill", int'(FILL), 4);
    chk("ovf_flag", int'(OVF), 1);
    for (int v = 1; v <= 4; v++) begin
      chk("drain_do", int'($signed(DO)), v);
      step(1'b0, 0, 1'b1);
    end
    chk("drain_fill", int'(FILL), 0);
    chk("drain_o_dv", int'(O_DV), 0);

    // Full FIFO with a same-cycle pop as a group completes
    pulse_reset();
    for (int v = 1; v <= 4; v++) group(10 * v, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 50, 1'b0);
    step(1'b1, 50, 1'b1);
    chk("fullpop_fill", int'(FILL), 4);
    chk("fullpop_ovf", int'(OVF), 0);
    for (int v = 2; v <= 5; v++) begin
      chk("fullpop_do", int'($signed(DO)), 10 * v);
      step(1'b0, 0, 1'b1);
    end

    // Idle gaps between strobes leave the phase untouched
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 8, 1'b1);
      if (i < 3) for (int k = 0; k < 3; k++) step(1'b0, 0, 1'b1);
    end
    chk("gap_o_dv", int'(O_DV), 1);
    chk("gap_do", int'($signed(DO)), 8);
    step(1'b0, 0, 1'b1);

    // Reset mid-group with queued results
    group(7, 1'b0);
    group(9, 1'b0);
    step(1'b1, 100, 1'b0);
    step(1'b1, 100, 1'b0);
    pulse_reset();
    group(4, 1'b1);
    chk("post_rst_do", int'($signed(DO)), 4);
    chk("post_rst_fill", int'(FILL), 1);
    step(1'b0, 0, 1'b1);
    chk("post_rst_stale", int'(O_DV), 0);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic [15:0] r;
      r = 16'($urandom);
      if (n == 300) pulse_reset();
      step(1'($urandom_range(0, 3) != 0), int'($signed(r)), 1'($urandom_range(0, 2) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
